// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, ROM address drive and IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter int unsigned N   = 32,
    parameter int unsigned INS = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic         branch_taken_i,
    input  logic [N-1:0] branch_target_i,
    input  logic [N-1:0] instruction_i,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] instr_o,
    output logic [N-1:0] pc_id_o,
    output logic         valid_o,
`ifdef FETCH_PERF_EN
    output logic [31:0]  fetch_count_o,
    output logic [31:0]  stall_count_o,
`endif
    output logic         done_o
);

    localparam logic ST_FETCH = 1'b0;
    localparam logic ST_DONE  = 1'b1;

    localparam logic [N-1:0] LP_INS  = N'(INS);
    localparam logic [N-1:0] LP_LAST = N'(INS - 1);

    logic [N-1:0] r_pc, r_instr, r_pc_id;
    logic         r_valid, r_state;

    logic [N-1:0] w_pc_d, w_instr_d, w_pc_id_d;
    logic         w_valid_d, w_state_d;
    logic         w_load;
    logic         w_advance;

    always_comb begin
        w_pc_d    = r_pc;
        w_instr_d = r_instr;
        w_pc_id_d = r_pc_id;
        w_valid_d = r_valid;
        w_state_d = r_state;
        w_load    = 1'b0;
        w_advance = 1'b0;

        if (branch_taken_i) begin
            w_valid_d = 1'b0;
            // Out-of-range target halts fetch instead of addressing past the ROM.
            if (branch_target_i >= LP_INS) begin
                w_state_d = ST_DONE;
            end else begin
                w_pc_d    = branch_target_i;
                w_state_d = ST_FETCH;
            end
        end else if (flush_i) begin
            w_valid_d = 1'b0;
            w_advance = !stall_i && (r_state == ST_FETCH);
        end else if (!stall_i) begin
            if (r_state == ST_FETCH) begin
                w_load    = 1'b1;
                w_instr_d = instruction_i;
                w_pc_id_d = r_pc;
                w_valid_d = 1'b1;
                w_advance = 1'b1;
            end else begin
                w_valid_d = 1'b0;
            end
        end

        if (w_advance) begin
            if (r_pc == LP_LAST) begin
                w_state_d = ST_DONE;
            end else begin
                w_pc_d = r_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_pc_id <= '0;
            r_valid <= 1'b0;
            r_state <= ST_FETCH;
        end else begin
            r_pc    <= w_pc_d;
            r_instr <= w_instr_d;
            r_pc_id <= w_pc_id_d;
            r_valid <= w_valid_d;
            r_state <= w_state_d;
        end
    end

    assign pc_o    = r_pc;
    assign instr_o = r_instr;
    assign pc_id_o = r_pc_id;
    assign valid_o = r_valid;
    assign done_o  = (r_state == ST_DONE);

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count, r_stall_count;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_load && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + 1'b1;
            end
            if (stall_i && !branch_taken_i && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign fetch_count_o = r_fetch_count;
    assign stall_count_o = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (INS=1000 and INS=8) against a behavioural model.
// Checks the FETCH_PERF_EN counters when that macro is defined.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_i, flush_i, br_i;
    logic [31:0] tgt_i;

    logic [31:0] pc[2], instr[2], pcid[2], rom_d[2];
    logic        valid[2], done[2];
`ifdef FETCH_PERF_EN
    logic [31:0] fc[2], sc[2];
`endif

    int unsigned ins_of[2] = '{1000, 8};

    assign rom_d[0] = pc[0] + 32'h100;
    assign rom_d[1] = pc[1] + 32'h100;

    fetch_unit #(.N(32), .INS(1000)) u0 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .branch_taken_i(br_i), .branch_target_i(tgt_i), .instruction_i(rom_d[0]),
        .pc_o(pc[0]), .instr_o(instr[0]), .pc_id_o(pcid[0]), .valid_o(valid[0]),
`ifdef FETCH_PERF_EN
        .fetch_count_o(fc[0]), .stall_count_o(sc[0]),
`endif
        .done_o(done[0])
    );

    fetch_unit #(.N(32), .INS(8)) u1 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .branch_taken_i(br_i), .branch_target_i(tgt_i), .instruction_i(rom_d[1]),
        .pc_o(pc[1]), .instr_o(instr[1]), .pc_id_o(pcid[1]), .valid_o(valid[1]),
`ifdef FETCH_PERF_EN
        .fetch_count_o(fc[1]), .stall_count_o(sc[1]),
`endif
        .done_o(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the architectural state the spec describes, one entry per instance.
    longint unsigned m_pc[2], m_instr[2], m_pcid[2], m_fc[2], m_sc[2];
    bit              m_valid[2], m_done[2];
    bit              m_on = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_pc[i] = 0; m_instr[i] = 0; m_pcid[i] = 0;
                m_valid[i] = 0; m_done[i] = 0; m_fc[i] = 0; m_sc[i] = 0;
            end else begin
                if (stall_i && !br_i && m_sc[i] < 64'hFFFF_FFFF) m_sc[i]++;
                if (br_i) begin
                    m_valid[i] = 0;
                    if (tgt_i >= ins_of[i]) m_done[i] = 1;
                    else begin m_pc[i] = tgt_i; m_done[i] = 0; end
                end else if (flush_i) begin
                    m_valid[i] = 0;
                    if (!stall_i && !m_done[i]) begin
                        if (m_pc[i] == ins_of[i] - 1) m_done[i] = 1;
                        else m_pc[i]++;
                    end
                end else if (!stall_i) begin
                    if (!m_done[i]) begin
                        m_instr[i] = m_pc[i] + 'h100;
                        m_pcid[i]  = m_pc[i];
                        m_valid[i] = 1;
                        if (m_fc[i] < 64'hFFFF_FFFF) m_fc[i]++;
                        if (m_pc[i] == ins_of[i] - 1) m_done[i] = 1;
                        else m_pc[i]++;
                    end else begin
                        m_valid[i] = 0;
                    end
                end
            end
        end
        if (!rst) m_on = 1;
    end

    always @(negedge clk) begin
        if (m_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d pc_o", i), pc[i], m_pc[i][31:0]);
                chk($sformatf("u%0d instr_o", i), instr[i], m_instr[i][31:0]);
                chk($sformatf("u%0d pc_id_o", i), pcid[i], m_pcid[i][31:0]);
                chk($sformatf("u%0d valid_o", i), 32'(valid[i]), 32'(m_valid[i]));
                chk($sformatf("u%0d done_o", i), 32'(done[i]), 32'(m_done[i]));
`ifdef FETCH_PERF_EN
                chk($sformatf("u%0d fetch_count_o", i), fc[i], m_fc[i][31:0]);
                chk($sformatf("u%0d stall_count_o", i), sc[i], m_sc[i][31:0]);
`endif
            end
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit s, input bit f, input bit b, input logic [31:0] t);
        rst = r; stall_i = s; flush_i = f; br_i = b; tgt_i = t;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        step(2);
        chk("reset pc_o", pc[0], 32'd0);
        chk("reset valid_o", 32'(valid[0]), 32'd0);

        // Free run from reset
        drive(1, 0, 0, 0, 0);
        step();
        chk("edge1 pc_id_o", pcid[0], 32'd0);
        chk("edge1 instr_o", instr[0], 32'h100);
        chk("edge1 valid_o", 32'(valid[0]), 32'd1);
        step();
        chk("edge2 pc_id_o", pcid[0], 32'd1);
        chk("edge2 instr_o", instr[0], 32'h101);
        step(3);
        chk("pre-stall pc_o", pc[0], 32'd5);

        // Stall three cycles at pc 5
        drive(1, 1, 0, 0, 0);
        step(3);
        chk("stall pc_o", pc[0], 32'd5);
        chk("stall pc_id_o", pcid[0], 32'd4);
        chk("stall instr_o", instr[0], 32'h104);
        chk("stall valid_o", 32'(valid[0]), 32'd1);
        drive(1, 0, 0, 0, 0);
        step();
        chk("post-stall pc_id_o", pcid[0], 32'd5);
        step();
        chk("pre-branch pc_o", pc[0], 32'd7);

        // Branch with stall at pc 7
        drive(1, 1, 0, 1, 40);
        step();
        chk("branch pc_o", pc[0], 32'd40);
        chk("branch bubble", 32'(valid[0]), 32'd0);
        chk("u1 branch oob done", 32'(done[1]), 32'd1);
        drive(1, 0, 0, 0, 0);
        step();
        chk("target instr_o", instr[0], 32'h128);
        chk("target pc_id_o", pcid[0], 32'd40);
        chk("target valid_o", 32'(valid[0]), 32'd1);

        // Reset mid-stream at pc 20
        drive(1, 0, 0, 1, 20);
        step();
        chk("pc before reset", pc[0], 32'd20);
        drive(0, 0, 0, 0, 0);
        step();
        chk("midreset pc_o", pc[0], 32'd0);
        chk("midreset instr_o", instr[0], 32'd0);
        chk("midreset valid_o", 32'(valid[0]), 32'd0);
        drive(1, 0, 0, 0, 0);
        step(10);
        chk("refetch pc_o", pc[0], 32'd10);
`ifdef FETCH_PERF_EN
        chk("fetch_count after 10", fc[0], 32'd10);
        chk("stall_count after reset", sc[0], 32'd0);
`endif

        // Out-of-range branch target
        drive(1, 0, 0, 1, 1000);
        step();
        chk("oob done_o", 32'(done[0]), 32'd1);
        chk("oob pc_o", pc[0], 32'd10);
        chk("oob valid_o", 32'(valid[0]), 32'd0);

        // Run small ROM to its end, then branch out of DONE
        drive(1, 0, 0, 1, 0);
        step();
        drive(1, 0, 0, 0, 0);
        step(8);
        chk("u1 last pc_id_o", pcid[1], 32'd7);
        chk("u1 last done_o", 32'(done[1]), 32'd1);
        step();
        chk("u1 halted pc_o", pc[1], 32'd7);
        chk("u1 halted valid_o", 32'(valid[1]), 32'd0);
        chk("u1 halted done_o", 32'(done[1]), 32'd1);
        drive(1, 0, 0, 1, 2);
        step();
        chk("u1 redirect done_o", 32'(done[1]), 32'd0);
        drive(1, 0, 0, 0, 0);
        step();
        chk("u1 redirect instr_o", instr[1], 32'h102);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom_range(0, 1010));
            drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 6), t);
            step();
        end

        drive(1, 0, 0, 0, 0);
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
